// File: rtl/load_pkg.sv
// +--------------------------------------------------------------------+
// | load_pkg : shared encodings for the load path (funct3, fault, FSM)  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package load_pkg;

    localparam int LOAD_XLEN = 32;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_ILLEGAL  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// +--------------------------------------------------------------------+
// | load_extract : byte/half/word lane select with sign/zero extension  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module load_extract
    import load_pkg::*;
(
    input  logic [1:0]           addr_lo_i,
    input  logic [2:0]           funct3_i,
    input  logic [LOAD_XLEN-1:0] rdata_i,
    output logic [LOAD_XLEN-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        // Halfword lane comes from addr[1] only; addr[0] is a misalign concern of the caller.
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
            F3_LH:   data_o = {{16{w_half[15]}}, w_half};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'h0, w_byte};
            F3_LHU:  data_o = {16'h0, w_half};
            default: data_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_align_unit.sv
// +--------------------------------------------------------------------+
// | load_align_unit : load request -> aligned read -> extended writeback|
// | Option LOAD_MISALIGN_TRAP_EN : fault misaligned LH/LHU/LW at accept |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault,
    output logic [1:0]      fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              fault_q, fault_d;
    fault_e            cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   w_ext;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_misalign;

    load_extract u_extract (
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .rdata_i   (mem_rdata),
        .data_o    (w_ext)
    );

`ifdef LOAD_MISALIGN_TRAP_EN
    assign w_misalign = (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && req_addr[0]) ||
                        ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        data_d  = data_q;
        fault_d = fault_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    rd_d    = req_rd;
                    data_d  = '0;
                    fault_d = 1'b0;
                    cause_d = FC_NONE;
                    cnt_d   = '0;
                    if (!f3_legal(req_funct3)) begin
                        fault_d = 1'b1;
                        cause_d = FC_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (w_misalign) begin
                        fault_d = 1'b1;
                        cause_d = FC_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response on the limit cycle still wins over the timeout.
                if (mem_rvalid) begin
                    data_d  = w_ext;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        fault_d = 1'b1;
                        cause_d = FC_TIMEOUT;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            default: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign mem_rd_en   = (state_q == ST_ISSUE);
    assign mem_addr    = {addr_q[XLEN-1:2], 2'b00};
    assign wb_valid    = (state_q == ST_RESP);
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

`default_nettype wire
